// File: rtl/calc_result_bcd_if.sv
// Handshake bundle for calc_result_bcd: result word in, packed BCD out.
// master: the surrounding logic (calculator core + display driver).
// slave : the conversion stage itself.
interface calc_result_bcd_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic [WIDTH-1:0]    in_data;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] out_bcd;
  logic                out_neg;
  logic                out_valid;
  logic                out_ready;
  logic                busy;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_bcd, out_neg, out_valid, busy
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_bcd, out_neg, out_valid, busy
  );
endinterface

// File: rtl/calc_result_bcd.sv
// calc_result_bcd: sequential double-dabble binary-to-BCD converter.
// Accepts one WIDTH-bit word in IDLE, performs one add-3/shift step per clock
// for WIDTH clocks, then holds the packed BCD result until consumed.
// Optional macro CALC_BCD_SIGNED_INPUT_EN: treat in_data as two's complement,
// convert its magnitude and report the sign on out_neg.
module calc_result_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input logic            clk,
  input logic            reset,
  calc_result_bcd_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     out_bcd_q, out_bcd_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic [BW-1:0]       bcd_adj;
  logic [BW+WIDTH-1:0] shifted;
  logic [WIDTH-1:0]    mag;
  logic                sign_in;

`ifdef CALC_BCD_SIGNED_INPUT_EN
  logic neg_q, neg_d;
  logic out_neg_q, out_neg_d;

  // Magnitude of a two's complement input; the most negative value maps to 2^(WIDTH-1).
  always_comb begin
    sign_in = bus.in_data[WIDTH-1];
    mag     = sign_in ? (~bus.in_data + WIDTH'(1)) : bus.in_data;
  end
`else
  // Unsigned build: the word is already the magnitude.
  always_comb begin
    sign_in = 1'b0;
    mag     = bus.in_data;
  end
`endif

  // Add-3 correction on every digit that would overflow past 9 after doubling.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  // Next-state and next-output computation; outputs are decodes of the next state.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    out_bcd_d = out_bcd_q;
`ifdef CALC_BCD_SIGNED_INPUT_EN
    neg_d     = neg_q;
    out_neg_d = out_neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d = SHIFT;
          bin_d   = mag;
          bcd_d   = '0;
          cnt_d   = '0;
`ifdef CALC_BCD_SIGNED_INPUT_EN
          neg_d   = sign_in;
`endif
        end
      end
      SHIFT: begin
        bcd_d = shifted[BW+WIDTH-1:WIDTH];
        bin_d = shifted[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d   = DONE;
          out_bcd_d = shifted[BW+WIDTH-1:WIDTH];
`ifdef CALC_BCD_SIGNED_INPUT_EN
          out_neg_d = neg_q;
`endif
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and registered outputs; asynchronous reset discards any conversion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      out_bcd_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CALC_BCD_SIGNED_INPUT_EN
      neg_q       <= 1'b0;
      out_neg_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      out_bcd_q   <= out_bcd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef CALC_BCD_SIGNED_INPUT_EN
      neg_q       <= neg_d;
      out_neg_q   <= out_neg_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_bcd   = out_bcd_q;
`ifdef CALC_BCD_SIGNED_INPUT_EN
  assign bus.out_neg   = out_neg_q;
`else
  assign bus.out_neg   = 1'b0;
`endif

endmodule

// File: tb/tb_calc_result_bcd.sv
// Bench for calc_result_bcd: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a decimal-arithmetic model.
module tb_calc_result_bcd;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int BW = 4 * D;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   acc_cyc = 0;

  calc_result_bcd_if #(.WIDTH(W), .DIGITS(D)) bus ();

  calc_result_bcd #(.WIDTH(W), .DIGITS(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Decimal digits by plain division; magnitude taken first in the signed build.
  function automatic logic [BW-1:0] to_bcd(input logic [W-1:0] v);
    int unsigned m;
    logic [BW-1:0] r;
    m = v;
`ifdef CALC_BCD_SIGNED_INPUT_EN
    if (v[W-1]) m = (1 << W) - m;
`endif
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic neg_of(input logic [W-1:0] v);
`ifdef CALC_BCD_SIGNED_INPUT_EN
    return v[W-1];
`else
    return 1'b0 & v[0];
`endif
  endfunction

  // Model: 0 = waiting for a word, 1 = converting (counts edges since accept), 2 = presenting.
  int            m_phase = 0;
  int            m_cnt   = 0;
  logic [BW-1:0] m_pend  = '0;
  logic          m_pneg  = 1'b0;
  logic [BW-1:0] m_last  = '0;
  logic          m_lneg  = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0;
      m_cnt   = 0;
      m_last  = '0;
      m_lneg  = 1'b0;
    end else begin
      case (m_phase)
        0: if (bus.in_valid) begin
             m_phase = 1;
             m_cnt   = 0;
             m_pend  = to_bcd(bus.in_data);
             m_pneg  = neg_of(bus.in_data);
           end
        1: begin
             m_cnt++;
             if (m_cnt == W) begin
               m_phase = 2;
               m_last  = m_pend;
               m_lneg  = m_pneg;
             end
           end
        default: if (bus.out_ready) m_phase = 0;
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready",  32'(bus.in_ready),  32'(m_phase == 0));
    chk("out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
    chk("busy",      32'(bus.busy),      32'(m_phase != 0));
    chk("out_bcd",   32'(bus.out_bcd),   32'(m_last));
    chk("out_neg",   32'(bus.out_neg),   32'(m_lneg));
  end

  // One full transaction with literal expectations; entered and left just after a negedge.
  task automatic send(input logic [W-1:0] d, input int stall, input logic [BW-1:0] exp,
                      input logic expneg, input logic noise);
    int n;
    int lat;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    bus.in_valid = noise;
    bus.in_data  = W'($urandom);
    lat = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 50) begin
      if (noise) bus.in_data = W'($urandom);
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(W));
    chk("lit_bcd", 32'(bus.out_bcd), 32'(exp));
    chk("lit_neg", 32'(bus.out_neg), 32'(expneg));
    bus.out_ready = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_bcd",   32'(bus.out_bcd),   32'(exp));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_hs", 32'(bus.in_ready), 32'd1);
    chk("valid_after_hs", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;
  endtask

  int a0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Model pins against hand-computed decimal values.
    chk("pin_255", 32'(to_bcd(8'd255)), 32'h255);
    chk("pin_99",  32'(to_bcd(8'd99)),  32'h099);
    chk("pin_80",  32'(to_bcd(8'h80)),  32'h128);

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.in_ready),  32'd1);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_bcd",   32'(bus.out_bcd),   32'd0);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    reset = 1'b0;
    @(negedge clk);

    send(8'd255, 0, 12'h255, 1'b0, 1'b0);

    send(8'd0, 0, 12'h000, 1'b0, 1'b1);
    a0 = acc_cyc;
    send(8'd8, 0, 12'h008, 1'b0, 1'b1);
    chk("accept_spacing", 32'(acc_cyc - a0), 32'(W + 2));

    send(8'd99, 5, 12'h099, 1'b0, 1'b0);

    // Reset four cycles into a conversion of 200.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd200;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(bus.in_ready),  32'd1);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_bcd",   32'(bus.out_bcd),   32'd0);
    chk("mid_rst_busy",  32'(bus.busy),      32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_emit_after_rst", 32'(bus.out_valid), 32'd0);
    end
    send(8'd15, 0, 12'h015, 1'b0, 1'b0);

`ifdef CALC_BCD_SIGNED_INPUT_EN
    send(8'hF6, 0, 12'h010, 1'b1, 1'b0);
    send(8'h80, 2, 12'h128, 1'b1, 1'b0);
`else
    send(8'hF6, 0, 12'h246, 1'b0, 1'b0);
    send(8'h80, 2, 12'h128, 1'b0, 1'b0);
`endif

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid  = 1'($urandom % 2);
      bus.in_data   = W'($urandom);
      bus.out_ready = (($urandom % 4) != 0);
      reset         = (($urandom % 150) == 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
